idli_cmp_m: RTL and testbench

//   Nibble-serial compare unit; direct upstream producer for the predicate register file.
//   - Takes two 16b operands LSB-first, one nibble per cycle, from the operand path.
//   - Evaluates the requested condition and issues a single-cycle write to the PRF Q write port.
//   - Writes for pd=P3 are dropped; P3 is hardwired to one.
//

---
 rtl/idli_pkg.sv | 27 ++
 rtl/idli_cmp_sub_m.sv | 14 +
 rtl/idli_cmp_m.sv | 162 ++++++++++++++++
 tb/tb_idli_cmp_m.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types for the idli compare path: condition codes, predicate register
// indices and the nibble-serial beat count.
package idli_pkg;

    localparam int CMP_WIDTH = 16;
    localparam int CMP_NIB   = 4;
    localparam int CMP_BEATS = CMP_WIDTH / CMP_NIB;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'd0,
        CMP_NE   = 3'd1,
        CMP_LT   = 3'd2,
        CMP_GE   = 3'd3,
        CMP_LTU  = 3'd4,
        CMP_GEU  = 3'd5,
        CMP_ANY  = 3'd6,
        CMP_NONE = 3'd7
    } cmp_op_t;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } preg_t;

endpackage

// File: rtl/idli_cmp_sub_m.sv
// One nibble of the serial subtract a - b - bin; only the borrow out is needed
// by the compare unit.
module idli_cmp_sub_m #(
    parameter int NIB = 4
) (
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           bin,
    output logic           bout
);

    assign bout = (a < b) | ((a == b) & bin);

endmodule

// File: rtl/idli_cmp_m.sv
// Nibble-serial compare unit feeding the predicate register file write port.
// Optional feature macro: IDLI_CMP_ANY_EN enables the ANY (bit test) condition.
import idli_pkg::*;

module idli_cmp_m #(
    parameter int WIDTH = CMP_WIDTH,
    parameter int NIB   = CMP_NIB
) (
    input  logic           i_cmp_gck,
    input  logic           i_cmp_rst_n,
    input  logic           i_cmp_start,
    input  cmp_op_t        i_cmp_op,
    input  preg_t          i_cmp_pd,
    input  logic [NIB-1:0] i_cmp_a,
    input  logic [NIB-1:0] i_cmp_b,
    input  logic           i_cmp_flush,
    output logic           o_cmp_busy,
    output preg_t          o_cmp_q,
    output logic           o_cmp_q_wr_en,
    output logic           o_cmp_q_data
);

    localparam int BEATS = WIDTH / NIB;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    function automatic logic cmp_result(input cmp_op_t op, input logic eq,
                                        input logic lt, input logic ltu,
                                        input logic any);
        case (op)
            CMP_EQ:  return eq;
            CMP_NE:  return ~eq;
            CMP_LT:  return lt;
            CMP_GE:  return ~lt;
            CMP_LTU: return ltu;
            CMP_GEU: return ~ltu;
            CMP_ANY: return any;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_writes(input cmp_op_t op);
        case (op)
            CMP_NONE: return 1'b0;
`ifdef IDLI_CMP_ANY_EN
            CMP_ANY:  return 1'b1;
`else
            CMP_ANY:  return 1'b0;
`endif
            default:  return 1'b1;
        endcase
    endfunction

    logic             busy_p0;
    logic [CNT_W-1:0] cnt_p0;
    cmp_op_t          op_p0;
    preg_t            pd_p0;
    logic             eq_p0;
    logic             brw_p0;

    logic             wr_en_p1;
    preg_t            q_p1;
    logic             data_p1;

    logic             vld_p0;
    logic [CNT_W-1:0] beat;
    cmp_op_t          op_cur;
    preg_t            pd_cur;
    logic             eq_in;
    logic             brw_in;
    logic             eq_nx;
    logic             brw_nx;
    logic             any_nx;
    logic             lt;
    logic             last_beat;
    logic             issue;
    logic             res;

    // Beat 0 comes straight from the start inputs; later beats use the held op.
    assign vld_p0    = (i_cmp_start | busy_p0) & ~i_cmp_flush;
    assign beat      = i_cmp_start ? '0 : cnt_p0;
    assign op_cur    = i_cmp_start ? i_cmp_op : op_p0;
    assign pd_cur    = i_cmp_start ? i_cmp_pd : pd_p0;
    assign eq_in     = i_cmp_start ? 1'b1 : eq_p0;
    assign brw_in    = i_cmp_start ? 1'b0 : brw_p0;
    assign eq_nx     = eq_in & (i_cmp_a == i_cmp_b);
    assign last_beat = vld_p0 & (beat == LAST);

    idli_cmp_sub_m #(.NIB(NIB)) u_sub (
        .a    (i_cmp_a),
        .b    (i_cmp_b),
        .bin  (brw_in),
        .bout (brw_nx)
    );

`ifdef IDLI_CMP_ANY_EN
    logic any_p0;
    logic any_in;
    assign any_in = i_cmp_start ? 1'b0 : any_p0;
    assign any_nx = any_in | (|(i_cmp_a & i_cmp_b));

    always_ff @(posedge i_cmp_gck) begin
        if (!i_cmp_rst_n) begin
            any_p0 <= 1'b0;
        end else if (vld_p0) begin
            any_p0 <= any_nx;
        end
    end
`else
    assign any_nx = 1'b0;
`endif

    // Signed order differs from unsigned only when the sign bits differ.
    assign lt    = (i_cmp_a[NIB-1] ^ i_cmp_b[NIB-1]) ? i_cmp_a[NIB-1] : brw_nx;
    assign res   = cmp_result(op_cur, eq_nx, lt, brw_nx, any_nx);
    assign issue = last_beat & op_writes(op_cur) & (pd_cur != P3);

    always_ff @(posedge i_cmp_gck) begin
        if (!i_cmp_rst_n) begin
            busy_p0  <= 1'b0;
            cnt_p0   <= '0;
            op_p0    <= CMP_EQ;
            pd_p0    <= P0;
            eq_p0    <= 1'b0;
            brw_p0   <= 1'b0;
            wr_en_p1 <= 1'b0;
            q_p1     <= P0;
            data_p1  <= 1'b0;
        end else begin
            wr_en_p1 <= issue;
            if (issue) begin
                q_p1    <= pd_cur;
                data_p1 <= res;
            end
            if (i_cmp_flush) begin
                busy_p0 <= 1'b0;
                cnt_p0  <= '0;
            end else if (vld_p0) begin
                eq_p0  <= eq_nx;
                brw_p0 <= brw_nx;
                if (i_cmp_start) begin
                    op_p0 <= i_cmp_op;
                    pd_p0 <= i_cmp_pd;
                end
                if (beat == LAST) begin
                    busy_p0 <= 1'b0;
                    cnt_p0  <= '0;
                end else begin
                    busy_p0 <= 1'b1;
                    cnt_p0  <= beat + 1'b1;
                end
            end
        end
    end

    // Output stage: strobe, index and result registered together.
    assign o_cmp_busy    = busy_p0;
    assign o_cmp_q_wr_en = wr_en_p1;
    assign o_cmp_q       = q_p1;
    assign o_cmp_q_data  = data_p1;

endmodule

// File: tb/tb_idli_cmp_m.sv
// Directed bench for idli_cmp_m; expected results are hand-computed per vector.
import idli_pkg::*;

module tb_idli_cmp_m;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    cmp_op_t    op_in;
    preg_t      pd_in;
    logic [3:0] a;
    logic [3:0] b;
    logic       flush;
    logic       busy;
    preg_t      q;
    logic       wr_en;
    logic       data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    idli_cmp_m dut (
        .i_cmp_gck     (clk),
        .i_cmp_rst_n   (rst_n),
        .i_cmp_start   (start),
        .i_cmp_op      (op_in),
        .i_cmp_pd      (pd_in),
        .i_cmp_a       (a),
        .i_cmp_b       (b),
        .i_cmp_flush   (flush),
        .o_cmp_busy    (busy),
        .o_cmp_q       (q),
        .o_cmp_q_wr_en (wr_en),
        .o_cmp_q_data  (data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one full compare starting this cycle (T); returns in cycle T+4.
    task automatic run_cmp(input cmp_op_t op, input preg_t pd, input logic [15:0] va,
                           input logic [15:0] vb, input logic exp_wr, input logic exp_d,
                           input string tag);
        for (int k = 0; k < 4; k++) begin
            start = (k == 0);
            op_in = op;
            pd_in = pd;
            a     = va[4*k +: 4];
            b     = vb[4*k +: 4];
            tick();
            if (k < 3) check({tag, "_early_wr"}, 32'(wr_en), 32'd0);
            if (k == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        start = 1'b0;
        check({tag, "_wr"}, 32'(wr_en), 32'(exp_wr));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        if (exp_wr) begin
            check({tag, "_q"}, 32'(q), 32'(pd));
            check({tag, "_data"}, 32'(data), 32'(exp_d));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_in = CMP_EQ;
        pd_in = P0;
        a     = 4'h0;
        b     = 4'h0;
        flush = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr", 32'(wr_en), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Equality, strobe exactly at T+4, then hold
        run_cmp(CMP_EQ, P1, 16'h1234, 16'h1234, 1'b1, 1'b1, "eq");
        tick();
        check("eq_t5_wr", 32'(wr_en), 32'd0);
        check("eq_hold_q", 32'(q), 32'd1);
        check("eq_hold_data", 32'(data), 32'd1);

        // Signed vs unsigned ordering
        run_cmp(CMP_LT,  P0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, "lt_m1");
        run_cmp(CMP_LTU, P0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, "ltu_m1");
        run_cmp(CMP_GEU, P0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, "geu_m1");
        run_cmp(CMP_LT,  P2, 16'h8000, 16'h7FFF, 1'b1, 1'b1, "lt_min");
        run_cmp(CMP_GE,  P2, 16'h8000, 16'h7FFF, 1'b1, 1'b0, "ge_min");
        run_cmp(CMP_LTU, P2, 16'h8000, 16'h7FFF, 1'b1, 1'b0, "ltu_min");
        run_cmp(CMP_NE,  P1, 16'h1234, 16'h1235, 1'b1, 1'b1, "ne_diff");
        run_cmp(CMP_EQ,  P1, 16'h1234, 16'hA234, 1'b1, 1'b0, "eq_msn");
        run_cmp(CMP_NONE, P1, 16'h1234, 16'h1234, 1'b0, 1'b0, "none");
        tick();

        // Back-to-back issue, then the same with the hardwired predicate
        run_cmp(CMP_EQ, P0, 16'h00AA, 16'h00AA, 1'b1, 1'b1, "b2b_eq");
        run_cmp(CMP_NE, P2, 16'h00AA, 16'h00AB, 1'b1, 1'b1, "b2b_ne");
        run_cmp(CMP_EQ, P3, 16'h00AA, 16'h00AA, 1'b0, 1'b0, "p3_eq");
        run_cmp(CMP_NE, P3, 16'h00AA, 16'h00AB, 1'b0, 1'b0, "p3_ne");
        check("p3_hold_q", 32'(q), 32'd2);
        tick();

        // Restart while busy: first op (unequal) discarded, second op issues
        start = 1'b1; op_in = CMP_EQ; pd_in = P0; a = 4'h1; b = 4'h2;
        tick();
        start = 1'b0;
        tick();
        run_cmp(CMP_EQ, P1, 16'h5A5A, 16'h5A5A, 1'b1, 1'b1, "restart");
        tick();

        // Flush together with start: nothing begins
        start = 1'b1; flush = 1'b1; op_in = CMP_EQ; pd_in = P0; a = 4'h3; b = 4'h3;
        tick();
        start = 1'b0; flush = 1'b0;
        check("fs_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        check("fs_wr", 32'(wr_en), 32'd0);
        tick();

        // Flush at T+2
        start = 1'b1; op_in = CMP_EQ; pd_in = P0; a = 4'h4; b = 4'h4;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", 32'(busy), 32'd0);
        tick();
        check("fl_wr", 32'(wr_en), 32'd0);
        tick();
        check("fl_t5_wr", 32'(wr_en), 32'd0);

        // Leave q/data non-zero, then reset at T+2
        run_cmp(CMP_EQ, P2, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1, "pre_rst");
        tick();
        start = 1'b1; op_in = CMP_EQ; pd_in = P1; a = 4'h7; b = 4'h7;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_wr", 32'(wr_en), 32'd0);
        check("mr_q", 32'(q), 32'd0);
        check("mr_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        tick();
        check("mr_t4_wr", 32'(wr_en), 32'd0);
        tick();
        check("mr_t5_wr", 32'(wr_en), 32'd0);

        // Bit test
`ifdef IDLI_CMP_ANY_EN
        run_cmp(CMP_ANY, P1, 16'h0100, 16'h0300, 1'b1, 1'b1, "any_hit");
        run_cmp(CMP_ANY, P1, 16'h0100, 16'h0200, 1'b1, 1'b0, "any_miss");
`else
        run_cmp(CMP_ANY, P1, 16'h0100, 16'h0300, 1'b0, 1'b0, "any_off");
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
